gmux_nway_arb: RTL and testbench

//  Parametrised N-way, W-bit multiplexer with registered output and valid/ready

---
 rtl/gmux_pkg.sv | 28 ++
 rtl/gmux_rr_pick.sv | 37 +++
 rtl/gmux_nway_arb.sv | 173 +++++++++++++++++
 tb/tb_gmux_nway_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gmux_pkg.sv
// gmux_pkg
//   Shared definitions for the gmux_nway_arb multiplexer family:
//   - GMUX_MODE_SEL / GMUX_MODE_RR : values for the MODE parameter
//   - lock_state_t                 : burst-lock state (used with GMUX_LOCK_EN)
//   - clog2()                      : elaboration-time ceiling log2
package gmux_pkg;

    localparam int unsigned GMUX_MODE_SEL = 0;
    localparam int unsigned GMUX_MODE_RR  = 1;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

    // Ceiling log2, at least 1 so a select field is never zero-width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gmux_rr_pick.sv
// gmux_rr_pick
//   Combinational rotating-priority encoder. Scans req starting at ptr+1,
//   wrapping modulo NUM_IN, and reports the first requesting index.
// Ports
//   req     in   NUM_IN  request vector
//   ptr     in   SEL_W   index granted last; it has lowest priority now
//   gnt_idx out  SEL_W   winning index (0 when gnt_any=0)
//   gnt_any out  1       at least one request present
module gmux_rr_pick #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            // ptr < NUM_IN, so one conditional subtract is enough to wrap.
            idx = 32'(ptr) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/gmux_nway_arb.sv
// gmux_nway_arb
//   N-way, W-bit multiplexer with a single registered output stage and
//   valid/ready handshake per channel. Source is picked by an external
//   select (MODE=GMUX_MODE_SEL) or a round-robin arbiter (MODE=GMUX_MODE_RR).
//   Optional macro GMUX_LOCK_EN adds burst locking via in_last/out_last.
// Ports
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous reset, active low
//   in_data    in   NUM_IN*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   NUM_IN        channel i has a beat
//   in_ready   out  NUM_IN        channel i beat accepted this cycle
//   sel        in   SEL_W         requested channel (ignored in RR mode)
//   in_last    in   NUM_IN        last beat of a burst (GMUX_LOCK_EN only)
//   out_last   out  1             registered last flag (GMUX_LOCK_EN only)
//   out_data   out  WIDTH         registered selected data
//   out_valid  out  1             out_data holds a beat
//   out_ready  in   1             consumer accepts the beat
//   out_src    out  SEL_W         channel that supplied out_data
module gmux_nway_arb
    import gmux_pkg::*;
#(
    parameter  int unsigned WIDTH  = 16,
    parameter  int unsigned NUM_IN = 4,
    parameter  int unsigned MODE   = GMUX_MODE_SEL,
    localparam int unsigned SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
`ifdef GMUX_LOCK_EN
    input  logic [NUM_IN-1:0]       in_last,
    output logic                    out_last,
`endif
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    logic             load;
    logic             accept;
    logic [SEL_W-1:0] base_idx;
    logic             base_any;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [WIDTH-1:0] gnt_data;
`ifdef GMUX_LOCK_EN
    logic             gnt_last;
    lock_state_t      lock_state;
    logic [SEL_W-1:0] lock_idx;
`endif

    // Output register can take a new beat when empty or being drained.
    assign load   = !out_valid || out_ready;
    assign accept = load && gnt_any;

    generate
        if (MODE == GMUX_MODE_RR) begin : g_rr
            logic [SEL_W-1:0] rr_ptr;
            logic             advance;

`ifdef GMUX_LOCK_EN
            // Pointer moves only when a burst completes.
            assign advance = accept && gnt_last;
`else
            assign advance = accept;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_ptr <= SEL_W'(NUM_IN - 1);
                end else if (advance) begin
                    rr_ptr <= gnt_idx;
                end
            end

            gmux_rr_pick #(
                .NUM_IN (NUM_IN),
                .SEL_W  (SEL_W)
            ) u_pick (
                .req     (in_valid),
                .ptr     (rr_ptr),
                .gnt_idx (base_idx),
                .gnt_any (base_any)
            );
        end else begin : g_sel
            // Out-of-range sel matches no channel and therefore grants nothing.
            always_comb begin
                base_idx = sel;
                base_any = 1'b0;
                for (int unsigned i = 0; i < NUM_IN; i++) begin
                    if (sel == SEL_W'(i)) begin
                        base_any = in_valid[i];
                    end
                end
            end
        end
    endgenerate

`ifdef GMUX_LOCK_EN
    // While locked, the burst owner overrides both sel and the rr scan.
    always_comb begin
        gnt_idx = base_idx;
        gnt_any = base_any;
        if (lock_state == LOCK_HELD) begin
            gnt_idx = lock_idx;
            gnt_any = 1'b0;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (lock_idx == SEL_W'(i)) begin
                    gnt_any = in_valid[i];
                end
            end
        end
    end
`else
    assign gnt_idx = base_idx;
    assign gnt_any = base_any;
`endif

    always_comb begin
        gnt_data = '0;
`ifdef GMUX_LOCK_EN
        gnt_last = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
`ifdef GMUX_LOCK_EN
                gnt_last = in_last[i];
`endif
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            in_ready[i] = accept && (gnt_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
                out_data <= gnt_data;
                out_src  <= gnt_idx;
            end
        end
    end

`ifdef GMUX_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_last   <= 1'b0;
            lock_state <= LOCK_IDLE;
            lock_idx   <= '0;
        end else if (accept) begin
            out_last   <= gnt_last;
            lock_state <= gnt_last ? LOCK_IDLE : LOCK_HELD;
            lock_idx   <= gnt_idx;
        end
    end
`endif

endmodule

// File: tb/tb_gmux_nway_arb.sv
// tb_gmux_nway_arb
//   Directed bench for gmux_nway_arb: one instance in select mode, one in
//   round-robin mode, sharing the stimulus. Lock scenario only when
//   GMUX_LOCK_EN is defined.
module tb_gmux_nway_arb;
    import gmux_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [1:0]  sel;
    logic        out_ready;
`ifdef GMUX_LOCK_EN
    logic [3:0]  in_last;
    logic        s_out_last, r_out_last;
`endif

    logic [3:0]  s_in_ready, r_in_ready;
    logic [15:0] s_out_data, r_out_data;
    logic        s_out_valid, r_out_valid;
    logic [1:0]  s_out_src, r_out_src;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_data [4];

    always #5 clk = ~clk;

    gmux_nway_arb #(.WIDTH(16), .NUM_IN(4), .MODE(GMUX_MODE_SEL)) u_sel (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .sel       (sel),
`ifdef GMUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (s_out_last),
`endif
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_src   (s_out_src)
    );

    gmux_nway_arb #(.WIDTH(16), .NUM_IN(4), .MODE(GMUX_MODE_RR)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (r_in_ready),
        .sel       (sel),
`ifdef GMUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (r_out_last),
`endif
        .out_data  (r_out_data),
        .out_valid (r_out_valid),
        .out_ready (out_ready),
        .out_src   (r_out_src)
    );

    // Leaves the bench just after a rising edge with reset released.
    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 4'h0;
        out_ready = 1'b0;
        sel       = 2'd0;
`ifdef GMUX_LOCK_EN
        in_last   = 4'h0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        sel       = 2'd2;
`ifdef GMUX_LOCK_EN
        in_last   = 4'h0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid: got %b expected 0", s_out_valid); end
        checks++; if (s_out_data !== 16'h0000) begin errors++; $display("FAIL reset_s_data: got %h expected 0000", s_out_data); end
        checks++; if (s_out_src !== 2'd0) begin errors++; $display("FAIL reset_s_src: got %0d expected 0", s_out_src); end
        checks++; if (r_out_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %b expected 0", r_out_valid); end
        checks++; if (r_out_data !== 16'h0000) begin errors++; $display("FAIL reset_r_data: got %h expected 0000", r_out_data); end
        checks++; if (r_out_src !== 2'd0) begin errors++; $display("FAIL reset_r_src: got %0d expected 0", r_out_src); end
        apply_reset();
    endtask

    task automatic test_sel();
        logic [1:0] idx;
        apply_reset();
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i);
            sel = idx;
            #1;
            checks++; if (s_in_ready !== 4'(1 << i)) begin errors++; $display("FAIL sel_ready[%0d]: got %b expected %b", i, s_in_ready, 4'(1 << i)); end
            @(posedge clk); #1;
            checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL sel_valid[%0d]: got %b expected 1", i, s_out_valid); end
            checks++; if (s_out_data !== exp_data[i]) begin errors++; $display("FAIL sel_data[%0d]: got %h expected %h", i, s_out_data, exp_data[i]); end
            checks++; if (s_out_src !== idx) begin errors++; $display("FAIL sel_src[%0d]: got %0d expected %0d", i, s_out_src, idx); end
        end
        in_valid = 4'h0;
        @(posedge clk); #1;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL sel_drain: got %b expected 0", s_out_valid); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (r_in_ready !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, r_in_ready, 4'(1 << (i % 4))); end
            @(posedge clk); #1;
            checks++; if (r_out_src !== 2'(i % 4)) begin errors++; $display("FAIL rr_src[%0d]: got %0d expected %0d", i, r_out_src, i % 4); end
            checks++; if (r_out_data !== exp_data[i % 4]) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, r_out_data, exp_data[i % 4]); end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        in_valid  = 4'hF;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (r_out_data !== 16'hAAAA) begin errors++; $display("FAIL stall_fill: got %h expected aaaa", r_out_data); end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel      = 2'(i + 1);
            in_valid = (i % 2 == 0) ? 4'h5 : 4'hF;
            #1;
            checks++; if (r_in_ready !== 4'h0) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 0000", i, r_in_ready); end
            @(posedge clk); #1;
            checks++; if (r_out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, r_out_valid); end
            checks++; if (r_out_data !== 16'hAAAA) begin errors++; $display("FAIL stall_data[%0d]: got %h expected aaaa", i, r_out_data); end
            checks++; if (r_out_src !== 2'd2) begin errors++; $display("FAIL stall_src[%0d]: got %0d expected 2", i, r_out_src); end
        end
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #1;
        checks++; if (r_in_ready !== 4'b1000) begin errors++; $display("FAIL stall_resume_ready: got %b expected 1000", r_in_ready); end
        @(posedge clk); #1;
        checks++; if (r_out_src !== 2'd3) begin errors++; $display("FAIL stall_resume_src: got %0d expected 3", r_out_src); end
        checks++; if (r_out_data !== 16'h5555) begin errors++; $display("FAIL stall_resume_data: got %h expected 5555", r_out_data); end
    endtask

    task automatic test_sparse();
        logic [1:0] exp_src [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        apply_reset();
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (r_out_src !== exp_src[i]) begin errors++; $display("FAIL sparse_src[%0d]: got %0d expected %0d", i, r_out_src, exp_src[i]); end
        end
        in_valid = 4'h0;
        #1;
        checks++; if (r_in_ready !== 4'h0) begin errors++; $display("FAIL idle_ready: got %b expected 0000", r_in_ready); end
        @(posedge clk); #1;
        checks++; if (r_out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", r_out_valid); end
        // Pointer must still be 3 after the idle cycle, so ch1 wins next.
        in_valid = 4'b1010;
        @(posedge clk); #1;
        checks++; if (r_out_src !== 2'd1) begin errors++; $display("FAIL idle_ptr_src: got %0d expected 1", r_out_src); end
        checks++; if (r_out_valid !== 1'b1) begin errors++; $display("FAIL idle_ptr_valid: got %b expected 1", r_out_valid); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        in_valid  = 4'hF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (r_out_data !== 16'hFFFF) begin errors++; $display("FAIL arst_pre_data: got %h expected ffff", r_out_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (r_out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", r_out_valid); end
        checks++; if (r_out_data !== 16'h0000) begin errors++; $display("FAIL arst_data: got %h expected 0000", r_out_data); end
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL arst_s_valid: got %b expected 0", s_out_valid); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (r_in_ready !== 4'b0001) begin errors++; $display("FAIL arst_first_ready: got %b expected 0001", r_in_ready); end
        @(posedge clk); #1;
        checks++; if (r_out_src !== 2'd0) begin errors++; $display("FAIL arst_first_src: got %0d expected 0", r_out_src); end
        checks++; if (r_out_valid !== 1'b1) begin errors++; $display("FAIL arst_first_valid: got %b expected 1", r_out_valid); end
    endtask

`ifdef GMUX_LOCK_EN
    task automatic test_lock();
        logic [3:0] last_tab [6] = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b1111};
        logic [3:0] rdy_tab  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        logic [1:0] src_tab  [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
        logic       olast    [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_reset();
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_last = last_tab[i];
            #1;
            checks++; if (r_in_ready !== rdy_tab[i]) begin errors++; $display("FAIL lock_ready[%0d]: got %b expected %b", i, r_in_ready, rdy_tab[i]); end
            @(posedge clk); #1;
            checks++; if (r_out_src !== src_tab[i]) begin errors++; $display("FAIL lock_src[%0d]: got %0d expected %0d", i, r_out_src, src_tab[i]); end
            checks++; if (r_out_last !== olast[i]) begin errors++; $display("FAIL lock_last[%0d]: got %b expected %b", i, r_out_last, olast[i]); end
            checks++; if (r_out_data !== exp_data[src_tab[i]]) begin errors++; $display("FAIL lock_data[%0d]: got %h expected %h", i, r_out_data, exp_data[src_tab[i]]); end
        end
    endtask
`endif

    initial begin
        exp_data[0] = 16'h0000;
        exp_data[1] = 16'hFFFF;
        exp_data[2] = 16'hAAAA;
        exp_data[3] = 16'h5555;
        in_data = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};

        test_reset();
        test_sel();
        test_back_to_back();
        test_stall();
        test_sparse();
        test_async_reset();
`ifdef GMUX_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
